clock_period_meter: RTL and testbench

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

---
 rtl/clock_period_meter.sv | 146 ++++++++++++++
 tb/tb_clock_period_meter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
// Measures the rising-to-rising period (and, with PERIOD_METER_DUTY_EN defined, the high time)
// of an asynchronous input in clock_in cycles; flags a sticky timeout when no rise arrives in time.
module clock_period_meter #(
    parameter int unsigned WIDTH       = 27,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             signal_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;

    logic synced;
    logic rise;
    logic restart;
    logic capture;
    logic count;

    // Synchronizer chain plus one history flop for edge detection
    assign sync_d = {sync_q[SYNC_STAGES-2:0], signal_in};
    assign synced = sync_q[SYNC_STAGES-1];
    assign hist_d = synced;
    assign rise   = synced & ~hist_q;

    // Next-state and counter control
    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        restart   = 1'b0;
        capture   = 1'b0;
        count     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    restart = 1'b1;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (rise) begin
                    capture   = 1'b1;
                    restart   = 1'b1;
                    timeout_d = 1'b0;
                end else if (cnt_q == CNT_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    count = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // count is only raised below CNT_MAX, so the period counter saturates without extra logic
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = capture;
        if (restart) begin
            cnt_d = CNT_ONE;
        end else if (count) begin
            cnt_d = cnt_q + CNT_ONE;
        end
        if (capture) begin
            period_d = cnt_q;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            hist_q    <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period  = period_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

`ifdef PERIOD_METER_DUTY_EN
    logic [WIDTH-1:0] hcnt_q, hcnt_d;
    logic [WIDTH-1:0] high_q, high_d;

    // High-time counter advances alongside cnt only while the synced level is high
    always_comb begin
        hcnt_d = hcnt_q;
        high_d = high_q;
        if (restart) begin
            hcnt_d = CNT_ONE;
        end else if (count && synced && (hcnt_q != CNT_MAX)) begin
            hcnt_d = hcnt_q + CNT_ONE;
        end
        if (capture) begin
            high_d = hcnt_q;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            high_q <= high_d;
        end
    end

    assign high_time = high_q;
`else
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: a default-width instance and a WIDTH=8 instance for timeout corners.
module tb_clock_period_meter;

`ifdef PERIOD_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sig;
    logic [26:0] period, high_time;
    logic        valid, timeout;
    logic [7:0]  period8, high8;
    logic        valid8, timeout8;

    always #5 clk = ~clk;

    clock_period_meter u_dut (
        .clock_in  (clk),
        .reset_n   (rst_n),
        .signal_in (sig),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout)
    );

    clock_period_meter #(.WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
        .clock_in  (clk),
        .reset_n   (rst_n),
        .signal_in (sig),
        .period    (period8),
        .high_time (high8),
        .valid     (valid8),
        .timeout   (timeout8)
    );

    int total = 0;
    int bad   = 0;

    int   pq[$];
    int   hq[$];
    int   v8cnt = 0;
    int   p8_last = 0;
    int   h8_last = 0;
    int   b2b = 0;
    logic valid_prev = 1'b0;
    logic valid8_prev = 1'b0;

    // Result monitor, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            pq.delete();
            hq.delete();
            v8cnt = 0;
        end else begin
            if (valid) begin
                pq.push_back(int'(period));
                hq.push_back(int'(high_time));
            end
            if (valid8) begin
                v8cnt   = v8cnt + 1;
                p8_last = int'(period8);
                h8_last = int'(high8);
            end
            if ((valid && valid_prev) || (valid8 && valid8_prev)) b2b = b2b + 1;
        end
        valid_prev  = valid;
        valid8_prev = valid8;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int cycles);
        sig = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        repeat (n) begin
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    // n full periods plus a closing rise, then enough low time for the last result to land
    task automatic stream(input int hi, input int lo, input int n);
        wave(hi, lo, n);
        hold(1'b1, hi);
        hold(1'b0, 8);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sig   = 1'b0;
        #1;
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_high", 32'(high_time), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_period8", 32'(period8), 32'd0);
        chk("rst_timeout8", 32'(timeout8), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, 2);
    endtask

    typedef struct {
        int hi;
        int lo;
        int n;
        int exp_p;
        int exp_h;
    } vec_t;

    vec_t vecs[7];
    int   sw_p[6];
    int   sw_h[6];

    initial begin
        vecs[0] = '{5, 5, 4, 10, 5};
        vecs[1] = '{1, 1, 4, 2, 1};
        vecs[2] = '{3, 4, 3, 7, 3};
        vecs[3] = '{1, 6, 3, 7, 1};
        vecs[4] = '{7, 1, 3, 8, 7};
        vecs[5] = '{2, 3, 4, 5, 2};
        vecs[6] = '{20, 13, 2, 33, 20};
        sw_p = '{10, 10, 10, 7, 7, 7};
        sw_h = '{5, 5, 5, 3, 3, 3};

        rst_n = 1'b1;
        sig   = 1'b0;
        @(negedge clk);

        // Steady square waves
        foreach (vecs[i]) begin
            do_reset();
            stream(vecs[i].hi, vecs[i].lo, vecs[i].n);
            chk($sformatf("v%0d_count", i), 32'(pq.size()), 32'(vecs[i].n));
            for (int k = 0; k < pq.size(); k++) begin
                chk($sformatf("v%0d_period%0d", i, k), 32'(pq[k]), 32'(vecs[i].exp_p));
                chk($sformatf("v%0d_high%0d", i, k), 32'(hq[k]), DUTY ? 32'(vecs[i].exp_h) : 32'd0);
            end
        end

        // Reset in the middle of a low phase discards the partial measurement
        do_reset();
        wave(5, 5, 2);
        hold(1'b1, 5);
        hold(1'b0, 2);
        chk("pre_reset_count", 32'(pq.size()), 32'd2);
        do_reset();
        stream(5, 5, 3);
        chk("post_reset_count", 32'(pq.size()), 32'd3);
        if (pq.size() > 0) begin
            chk("post_reset_period", 32'(pq[0]), 32'd10);
            chk("post_reset_high", 32'(hq[0]), DUTY ? 32'd5 : 32'd0);
        end

        // Period switches from 10 to 7 between rises
        do_reset();
        wave(5, 5, 3);
        stream(3, 4, 3);
        chk("switch_count", 32'(pq.size()), 32'd6);
        for (int k = 0; k < pq.size() && k < 6; k++) begin
            chk($sformatf("switch_period%0d", k), 32'(pq[k]), 32'(sw_p[k]));
            chk($sformatf("switch_high%0d", k), 32'(hq[k]), DUTY ? 32'(sw_h[k]) : 32'd0);
        end

        // WIDTH=8: timeout lands exactly 255 cycles after the registered rise
        do_reset();
        hold(1'b1, 1);
        hold(1'b0, 256);
        chk("w8_timeout_early", 32'(timeout8), 32'd0);
        hold(1'b0, 1);
        chk("w8_timeout_set", 32'(timeout8), 32'd1);
        chk("w8_timeout_no_valid", 32'(v8cnt), 32'd0);
        stream(5, 5, 1);
        chk("w8_recover_count", 32'(v8cnt), 32'd1);
        chk("w8_recover_period", 32'(p8_last), 32'd10);
        chk("w8_recover_timeout", 32'(timeout8), 32'd0);

        // WIDTH=8: rise on the saturation cycle wins over timeout
        do_reset();
        hold(1'b1, 1);
        hold(1'b0, 254);
        hold(1'b1, 1);
        hold(1'b0, 6);
        chk("w8_sat_count", 32'(v8cnt), 32'd1);
        chk("w8_sat_period", 32'(p8_last), 32'd255);
        chk("w8_sat_high", 32'(h8_last), DUTY ? 32'd1 : 32'd0);
        chk("w8_sat_timeout", 32'(timeout8), 32'd0);
        chk("wide_255_count", 32'(pq.size()), 32'd1);
        if (pq.size() > 0) chk("wide_255_period", 32'(pq[0]), 32'd255);

        // WIDTH=8: one cycle later the timeout fires first and the rise only re-arms
        do_reset();
        hold(1'b1, 1);
        hold(1'b0, 255);
        hold(1'b1, 1);
        hold(1'b0, 6);
        chk("w8_256_count", 32'(v8cnt), 32'd0);
        chk("w8_256_timeout", 32'(timeout8), 32'd1);
        chk("wide_256_count", 32'(pq.size()), 32'd1);
        if (pq.size() > 0) chk("wide_256_period", 32'(pq[0]), 32'd256);
        chk("wide_no_timeout", 32'(timeout), 32'd0);

        chk("no_back_to_back_valid", 32'(b2b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
